lane_subtractor: RTL
====================

Name: lane_subtractor

Overview:
- Sequential, handshaked successor to the combinational A-minus-B amplitude subtractor used in the Grover diffusion path.
- Accepts one frame per transfer: a reference value A plus all 2^NUM_QUBIT amplitudes.
- Streams results out LANES amplitudes per beat, with a per-frame operation mode that includes the 2*mean - x inversion.
- Sits between the accumulator/mean stage and the amplitude register file.

Parameters:
- NUM_QUBIT, 4, number of qubits; frame holds NUM_B_INPUT = 2^NUM_QUBIT amplitudes.
- DATA_WIDTH, 32, amplitude and result width in bits.
- LANES, 4, results per output beat; power of two, 1 <= LANES <= NUM_B_INPUT.
- Derived: NUM_BEATS = NUM_B_INPUT/LANES; BEAT_W = max(1, clog2(NUM_BEATS)).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  frame valid.
- in_ready  output  1  frame accept.
- in_mode  input  2  operation for this frame.
- in_a  input  DATA_WIDTH+NUM_QUBIT  reference operand A.
- in_b  input  DATA_WIDTH*NUM_B_INPUT  amplitudes; element j at [DATA_WIDTH*(j+1)-1 -: DATA_WIDTH].
- out_valid  output  1  beat valid.
- out_ready  input  1  beat accept.
- out_data  output  DATA_WIDTH*LANES  lane k at [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH].
- out_beat  output  BEAT_W  index of the current beat.
- out_last  output  1  high on the final beat of the frame.
- out_ovf  output  1  saturation flag for the current beat.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, out_beat=0, out_last=0, out_ovf=0.
  - Stored A, B and mode are don't-care after reset.
  - Reset asserted mid-frame aborts the frame; no further beats are issued.
- FSM, two states, IDLE and RUN. in_ready = (state==IDLE).
- IDLE:
  - On in_valid=1, capture in_a, in_b and in_mode, then go to RUN.
  - In the same edge, load the output register with beat 0 computed from the incoming data.
  - out_valid=1 the cycle after acceptance (latency 1).
- RUN:
  - Output register is held stable while out_valid && !out_ready.
  - On handshake with out_beat < NUM_BEATS-1: out_beat+1 and next lanes loaded on the following edge. No bubble; one beat per cycle under full ready.
  - On handshake of the last beat: out_valid=0 and return to IDLE. in_ready=1 in the next cycle.
  - in_valid during RUN is ignored; the frame is not accepted.
  - Minimum period is NUM_BEATS+1 cycles per frame.
- Element mapping: lane k of beat m is element j = m*LANES+k.
- out_last = out_valid && (out_beat==NUM_BEATS-1). When NUM_BEATS=1, every beat is last.
- Modes, with B[j] sign-extended to DATA_WIDTH+NUM_QUBIT+2 bits and A treated as signed:
  - 00: A - B[j]
  - 01: B[j] - A
  - 10: 2*A - B[j] (inversion about the mean)
  - 11: B[j] (pass-through)
- Arithmetic is computed at full width (DATA_WIDTH+NUM_QUBIT+2), so no intermediate overflow.
- Result without the feature is the low DATA_WIDTH bits, i.e. two's-complement wrap. Mode 00 therefore matches the legacy subtractor bit-for-bit.
- out_ovf=0 whenever the feature is disabled.

Optional Feature:
- Macro: LANE_SUBTRACTOR_SAT_EN.
- Defined:
  - Each lane result is clamped to signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - out_ovf = OR of per-lane clamp events in the current beat, registered with out_data.
- Undefined:
  - Wrap to low DATA_WIDTH bits.
  - out_ovf tied 0.
  - No clamp logic is synthesised.

Test Plan (NUM_QUBIT=4, DATA_WIDTH=32, LANES=4, so 4 beats):
- rst=1 for 2 cycles, then released -> in_ready=1, out_valid=0, out_data=0, out_ovf=0.
- Mode 00, A=100, B[j]=j, out_ready=1 -> beats on 4 consecutive cycles starting 1 cycle after accept. Beat0 lanes0..3 = 100,99,98,97; beat3 = 88,87,86,85 with out_last=1. in_ready=1 the cycle after beat3.
- Same frame with out_ready=0 for 3 cycles during beat1 -> out_data and out_beat=1 stable throughout the stall. in_valid pulsed during RUN is not accepted.
- Mode 10, A=5, B[j]=20 -> every lane 0xFFFFFFF6. Mode 01, A=1, B[j]=0 -> 0xFFFFFFFF. Mode 11 -> lanes equal B[j].
- Mode 10, A=0x07FFFFFFF, B[j]=0:
  - With LANE_SUBTRACTOR_SAT_EN: lanes 0x7FFFFFFF, out_ovf=1.
  - Without the macro: lanes 0xFFFFFFFE, out_ovf=0.
- rst=1 during beat 2 -> next cycle out_valid=0, in_ready=1. A new frame is then accepted and restarts at out_beat=0 with correct data.

Source files
------------

// File: rtl/lane_subtractor.sv
// lane_subtractor: handshaked frame subtractor streaming LANES results per beat.
// Optional saturation is enabled by defining LANE_SUBTRACTOR_SAT_EN.
module lane_subtractor #(
    parameter int NUM_QUBIT  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    localparam int NUM_B_INPUT = 2 ** NUM_QUBIT,
    localparam int NUM_BEATS   = NUM_B_INPUT / LANES,
    localparam int BEAT_W      = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        in_mode,
    input  logic [DATA_WIDTH+NUM_QUBIT-1:0]   in_a,
    input  logic [DATA_WIDTH*NUM_B_INPUT-1:0] in_b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH*LANES-1:0]       out_data,
    output logic [BEAT_W-1:0]                 out_beat,
    output logic                              out_last,
    output logic                              out_ovf
);
    localparam int AW = DATA_WIDTH + NUM_QUBIT;
    localparam int FW = AW + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                            state;
    logic [AW-1:0]                     a_q, src_a;
    logic [DATA_WIDTH*NUM_B_INPUT-1:0] b_q, src_b;
    logic [1:0]                        mode_q, src_mode;
    logic [BEAT_W-1:0]                 nxt_beat;
    logic [DATA_WIDTH*LANES-1:0]       nxt_data;
    logic                              at_last, load;

    // Full-width result of one lane; wide enough that no mode can overflow.
    function automatic logic signed [FW-1:0] calc(input logic [1:0] m, input logic [AW-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        logic signed [FW-1:0] sa, sb;
        sa = {{2{a[AW-1]}}, a};
        sb = {{(FW-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
        return m == 2'd0 ? sa - sb : m == 2'd1 ? sb - sa : m == 2'd2 ? (sa <<< 1) - sb : sb;
    endfunction

    assign in_ready = state == IDLE;
    assign at_last  = out_beat == BEAT_W'(NUM_BEATS - 1);
    assign out_last = out_valid && at_last;
    assign src_a    = state == IDLE ? in_a : a_q;
    assign src_b    = state == IDLE ? in_b : b_q;
    assign src_mode = state == IDLE ? in_mode : mode_q;
    assign nxt_beat = (state == IDLE || NUM_BEATS == 1) ? '0 : out_beat + BEAT_W'(1);
    assign load     = state == IDLE ? in_valid : out_ready && !at_last;

`ifdef LANE_SUBTRACTOR_SAT_EN
    localparam logic signed [FW-1:0] MAXV = {{(FW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [FW-1:0] MINV = {{(FW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    logic nxt_ovf;

    // Next beat's lanes, clamped to the signed result range, with clamp flag.
    always_comb begin
        logic signed [FW-1:0] f;
        nxt_data = '0;
        nxt_ovf  = 1'b0;
        f        = '0;
        for (int k = 0; k < LANES; k++) begin
            f = calc(src_mode, src_a, src_b[DATA_WIDTH*(int'(nxt_beat)*LANES+k) +: DATA_WIDTH]);
            nxt_data[DATA_WIDTH*k +: DATA_WIDTH] = f > MAXV ? DATA_WIDTH'(MAXV) :
                                                   f < MINV ? DATA_WIDTH'(MINV) : DATA_WIDTH'(f);
            nxt_ovf = nxt_ovf | (f > MAXV) | (f < MINV);
        end
    end

    // Saturation flag travels with the beat it describes.
    always_ff @(posedge clk) begin
        if (rst) out_ovf <= 1'b0;
        else if (load) out_ovf <= nxt_ovf;
    end
`else
    // Next beat's lanes, two's-complement wrapped to the result width.
    always_comb begin
        nxt_data = '0;
        for (int k = 0; k < LANES; k++)
            nxt_data[DATA_WIDTH*k +: DATA_WIDTH] =
                DATA_WIDTH'(calc(src_mode, src_a, src_b[DATA_WIDTH*(int'(nxt_beat)*LANES+k) +: DATA_WIDTH]));
    end

    assign out_ovf = 1'b0;
`endif

    // Frame capture, beat sequencing and output register; beat 0 loads on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beat  <= '0;
        end else begin
            if (load) begin
                out_data <= nxt_data;
                out_beat <= nxt_beat;
            end
            if (state == IDLE && in_valid) begin
                a_q       <= in_a;
                b_q       <= in_b;
                mode_q    <= in_mode;
                state     <= RUN;
                out_valid <= 1'b1;
            end else if (state == RUN && out_ready && at_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end
endmodule
